mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single synchronous-read memory port between the CPU's instruction-fetch requester and its load/store requester, so the core can run from one unified instruction/data RAM. Each requester uses a req/ready handshake and receives a one-cycle rvalid response pulse. Internally the block sequences every access through a three-state machine: accept, issue, response. It sits between the core's iaddr/idata and daddr/drdata/dwdata/dwe buses and the memory macro.

## Interface
- AW, 32, address width
- DW, 32, data width (byte enables = DW/8)
- STARVE_LIMIT, 4, consecutive data wins against a waiting fetch before fetch is forced (fixed-priority mode only)

Clock and reset: reset reset, synchronous, active-high; clock clk.

- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch request
- if_addr  in  AW  fetch address
- if_ready  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid pulse
- if_rdata  out  DW  fetch data
- d_req  in  1  data request
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_we  in  DW/8  byte write enables (0 = load)
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  load data / store acknowledge pulse
- d_rdata  out  DW  load data
- m_en  out  1  memory access strobe
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_we  out  DW/8  memory byte enables
- m_rdata  in  DW  memory read data, valid the cycle after m_en

## Operation
- States:
  - IDLE: arbitrate and accept.
  - ISSUE: drive the memory command.
  - RESP: deliver the response to the owner.
- Transitions:
  - IDLE→ISSUE on any accept.
  - ISSUE→RESP unconditionally.
  - RESP→IDLE unconditionally.
  - No accept occurs outside IDLE.
- Acceptance: in IDLE, a request is accepted when req & ready. ready is combinational from state and grant; it is 0 in ISSUE, RESP and during reset.
- Requesters hold req and their address/data stable until ready. Dropping req before ready is legal and leaves no side effect.
- On accept, the block latches the address, wdata, we and the owner into internal registers. Fetch we is forced to 0.
- ISSUE: m_en=1; m_addr, m_wdata and m_we come from the latched registers.
- RESP: the owner's rvalid=1 for exactly one cycle, and the owner's rdata = m_rdata. rdata is 0 whenever rvalid=0. Stores also get an rvalid (acknowledge); d_rdata is then whatever m_rdata holds.
- Single requester: granted immediately.
- Grant on conflict, default (macro undefined): data wins.
  - starve_cnt increments (saturating at STARVE_LIMIT) each time data wins while if_req=1.
  - When starve_cnt==STARVE_LIMIT and if_req=1, fetch wins.
  - starve_cnt clears whenever fetch is granted.
- Outputs when not in ISSUE: m_en=0, m_we=0, and m_addr/m_wdata hold their last values.

## Timing
- Accept in cycle N → m_en in N+1 → rvalid in N+2 → IDLE in N+3, where the next accept is possible.
- Latency: 2 cycles from accept to rvalid. Throughput: one access per 3 cycles.
- Reset values: state IDLE; m_en=0, m_we=0, m_addr=0, m_wdata=0; if_rvalid=d_rvalid=0; if_rdata=d_rdata=0; starve_cnt=0; rr pointer favours fetch.
- Reset mid-transaction (ISSUE or RESP) abandons the access. No rvalid is produced. If reset is asserted in the ISSUE cycle, m_en is 0 in that same cycle, because reset overrides the registered command.
- A new req arriving while the block is busy waits with ready=0. No request is dropped or queued internally.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On conflict, the requester not granted most recently wins.
  - A single-bit last-owner register updates on each accept.
  - After reset, the first conflict goes to fetch.
  - starve_cnt and STARVE_LIMIT are unused and not synthesized.
- Undefined: fixed data priority with the starvation counter, as described in Operation.

## Test plan
- Lone fetch: if_req=1, if_addr=0x100, memory returns 0x00000013 → m_en with m_addr=0x100 at N+1; if_rvalid=1 and if_rdata=0x00000013 at N+2; if_ready next high at N+3.
- Store then load: d_we=4'b0011 to 0x200 with wdata 0xDEADBEEF, then load 0x200 → m_we=4'b0011 in the store's ISSUE cycle; store ack d_rvalid=1; load d_rdata=0x0000BEEF.
- Conflict, default build: if_req and d_req held high continuously with STARVE_LIMIT=4 → grant order D,D,D,D,F,D,D,D,D,F…; starve_cnt never exceeds 4.
- Conflict with ARB_ROUND_ROBIN_EN: both held high from reset → grants alternate F,D,F,D; every owner's rvalid appears 2 cycles after its accept.
- Reset in the ISSUE cycle of a load to 0x40 → m_en=0 that cycle; no d_rvalid afterwards; state IDLE; the next request is accepted on the first cycle after reset deasserts.
- req withdrawn: d_req pulsed for one cycle while a fetch is in RESP → no data access is ever issued; m_en shows only the fetch.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous-read memory port between the instruction-fetch
//   requester (if_*) and the load/store requester (d_*). Every access goes
//   through three states: IDLE (arbitrate/accept), ISSUE (memory command),
//   and RESP (one-cycle rvalid pulse to the owner).
//
//   Parameters
//     AW            address width
//     DW            data width (byte enables are DW/8 bits)
//     STARVE_LIMIT  consecutive data wins over a waiting fetch before the
//                   fetch is forced through (fixed-priority build only)
//
//   Ports
//     clk, reset               clock; synchronous active-high reset
//     if_req/if_addr           fetch request and address
//     if_ready                 fetch accepted this cycle
//     if_rvalid/if_rdata       fetch response pulse and data
//     d_req/d_addr/d_wdata     data request, address, store data
//     d_we                     byte write enables (0 = load)
//     d_ready                  data request accepted this cycle
//     d_rvalid/d_rdata         load data / store acknowledge pulse
//     m_en/m_addr/m_wdata/m_we memory command (valid while m_en=1)
//     m_rdata                  memory read data, valid the cycle after m_en
//
//   Build option
//     ARB_ROUND_ROBIN_EN  when defined, conflicts go to the requester that
//                         was not granted most recently (fetch first after
//                         reset); otherwise data has priority, bounded by
//                         the starvation counter.

module mem_port_arbiter #(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset,
   // instruction fetch requester
   input  logic            if_req,
   input  logic [AW-1:0]   if_addr,
   output logic            if_ready,
   output logic            if_rvalid,
   output logic [DW-1:0]   if_rdata,
   // load/store requester
   input  logic            d_req,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_we,
   output logic            d_ready,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   // memory port
   output logic            m_en,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_we,
   input  logic [DW-1:0]   m_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t state, state_nxt;

   // arbitration result (only meaningful in IDLE)
   logic grant_if;
   logic grant_d;
   logic idle;
   logic accept;

   // latched command
   logic            own_d_q;   // 1: data requester owns the access
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW/8-1:0] we_q;

   logic issue_act;
   logic resp_act;

`ifdef ARB_ROUND_ROBIN_EN
   // 1: data was granted most recently. Resets to 1 so fetch wins first.
   logic last_d_q;
`else
   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt;
`endif

   //---------------------------------------------------------------------
   // Arbitration
   //---------------------------------------------------------------------
   always_comb begin
      grant_if = 1'b0;
      grant_d  = 1'b0;
      if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (last_d_q) begin
            grant_if = 1'b1;
         end else begin
            grant_d = 1'b1;
         end
`else
         if (starve_cnt == LIMIT) begin
            grant_if = 1'b1;
         end else begin
            grant_d = 1'b1;
         end
`endif
      end else begin
         grant_if = if_req;
         grant_d  = d_req;
      end
   end

   // ready is forced low during reset so nothing is accepted that cycle
   assign idle     = (state == IDLE) && !reset;
   assign if_ready = idle && grant_if;
   assign d_ready  = idle && grant_d;
   assign accept   = if_ready || d_ready;

   //---------------------------------------------------------------------
   // State machine
   //---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   //---------------------------------------------------------------------
   // Command latch. Store data is only captured on a data accept so that
   // m_wdata keeps its last value across fetches.
   //---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         own_d_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= '0;
      end else if (accept) begin
         own_d_q <= d_ready;
         if (d_ready) begin
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            we_q    <= d_we;
         end else begin
            addr_q  <= if_addr;
            we_q    <= '0;
         end
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         last_d_q <= 1'b1;
      end else if (accept) begin
         last_d_q <= d_ready;
      end
   end
`else
   // Counts data wins taken while a fetch was waiting; saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (if_ready) begin
         starve_cnt <= '0;
      end else if (d_ready && if_req && (starve_cnt != LIMIT)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`endif

   //---------------------------------------------------------------------
   // Memory command and responses. Reset gates the strobes combinationally
   // so an access caught by reset in ISSUE or RESP never reaches the
   // memory or the requester.
   //---------------------------------------------------------------------
   assign issue_act = (state == ISSUE) && !reset;
   assign resp_act  = (state == RESP)  && !reset;

   assign m_en    = issue_act;
   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;
   assign m_we    = issue_act ? we_q : '0;

   assign if_rvalid = resp_act && !own_d_q;
   assign d_rvalid  = resp_act &&  own_d_q;
   assign if_rdata  = if_rvalid ? m_rdata : '0;
   assign d_rdata   = d_rvalid  ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_we;
   logic        d_ready, d_rvalid;
   logic [31:0] d_rdata;
   logic        m_en;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_we;
   logic [31:0] m_rdata;

   mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
      .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_en(m_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
      .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
      end
   endtask

   // environment memory: synchronous read, byte-enable write
   logic [31:0] envmem [0:255];
   always @(posedge clk) begin
      if (m_en) begin
         m_rdata <= envmem[m_addr[9:2]];
         for (int b = 0; b < 4; b++)
            if (m_we[b]) envmem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end
   end

   // reference model: transaction queue stamped with accept cycle
   typedef struct {
      int          acc;
      bit          own_d;
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      logic [31:0] rd;
   } txn_t;

   txn_t        q[$];
   logic [31:0] gold [0:255];
   int          tcyc = 0;
   int          streak = 0;
   bit          last_d = 1'b1;
   logic [31:0] last_addr = '0;
   bit          acc_if = 1'b0;
   bit          acc_d = 1'b0;

   always @(negedge clk) begin : compare
      bit   iss, rsp, e_ifr, e_dr, own;
      txn_t t;
      tcyc++;
      acc_if = 1'b0;
      acc_d  = 1'b0;
      if (reset) begin
         q.delete();
         streak    = 0;
         last_d    = 1'b1;
         last_addr = '0;
         chk("rst_if_ready", if_ready, 0);
         chk("rst_d_ready", d_ready, 0);
         chk("rst_m_en", m_en, 0);
         chk("rst_m_we", m_we, 0);
         chk("rst_if_rvalid", if_rvalid, 0);
         chk("rst_d_rvalid", d_rvalid, 0);
         chk("rst_if_rdata", if_rdata, 0);
         chk("rst_d_rdata", d_rdata, 0);
      end else begin
         iss = (q.size() > 0) && (q[0].acc == tcyc - 1);
         rsp = (q.size() > 0) && (q[0].acc == tcyc - 2);
         own = (q.size() > 0) && q[0].own_d;
         e_ifr = 1'b0;
         e_dr  = 1'b0;
         if (q.size() == 0) begin
            if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
               if (last_d) e_ifr = 1'b1; else e_dr = 1'b1;
`else
               if (streak >= LIMIT) e_ifr = 1'b1; else e_dr = 1'b1;
`endif
            end else begin
               e_ifr = if_req;
               e_dr  = d_req;
            end
         end
         chk("if_ready", if_ready, e_ifr);
         chk("d_ready", d_ready, e_dr);
         chk("m_en", m_en, iss);
         if (iss) begin
            if (q[0].we != 0) begin
               for (int b = 0; b < 4; b++)
                  if (q[0].we[b]) gold[q[0].addr[9:2]][8*b +: 8] = q[0].wdata[8*b +: 8];
               chk("m_wdata", m_wdata, q[0].wdata);
            end else begin
               q[0].rd = gold[q[0].addr[9:2]];
            end
            last_addr = q[0].addr;
            chk("m_we", m_we, q[0].we);
         end else begin
            chk("m_we_idle", m_we, 0);
         end
         chk("m_addr", m_addr, last_addr);
         chk("if_rvalid", if_rvalid, rsp && !own);
         chk("d_rvalid", d_rvalid, rsp && own);
         chk("if_rdata", if_rdata, (rsp && !own) ? q[0].rd : 32'h0);
         if (rsp && own) begin
            if (q[0].we == 0) chk("d_rdata", d_rdata, q[0].rd);
         end else begin
            chk("d_rdata_zero", d_rdata, 0);
         end
         if (rsp) void'(q.pop_front());
         if (e_ifr || e_dr) begin
            t.acc   = tcyc;
            t.own_d = e_dr;
            t.addr  = e_dr ? d_addr : if_addr;
            t.we    = e_dr ? d_we : 4'h0;
            t.wdata = d_wdata;
            t.rd    = '0;
            q.push_back(t);
            if (e_ifr) streak = 0;
            else if (if_req && streak < LIMIT) streak++;
            last_d = e_dr;
            acc_if = e_ifr;
            acc_d  = e_dr;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int got;
   int men_cnt;
   bit exp_d;

   initial begin
      for (int i = 0; i < 256; i++) begin
         envmem[i] = '0;
         gold[i]   = '0;
      end
      envmem[8'h40] = 32'h0000_0013;
      gold[8'h40]   = 32'h0000_0013;
      m_rdata = '0;
      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we = '0;

      // conflict from reset: both held high continuously
      if_req = 1'b1; if_addr = 32'h100;
      d_req  = 1'b1; d_addr  = 32'h200; d_we = 4'h0;
      step(); step(); step();
      reset = 1'b0;
      got = 0;
      #2;
      for (int c = 0; c < 60 && got < 10; c++) begin
         if (if_ready || d_ready) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = (got % 2) == 1;
`else
            exp_d = (got % 5) != 4;
`endif
            chk("conflict_grant_is_data", d_ready, exp_d);
            got++;
         end
         if (got < 10) begin
            step();
            #2;
         end
      end
      chk("conflict_grant_count", got, 10);
      step();
      if_req = 1'b0; d_req = 1'b0;
      reset = 1'b1;
      step(); step();
      reset = 1'b0;

      // lone fetch, held so the follow-up accept lands at N+3
      step(); if_req = 1'b1; if_addr = 32'h100; #2;
      chk("lone_fetch_ready_N", if_ready, 1);
      step(); #2;
      chk("lone_fetch_men_N1", m_en, 1);
      chk("lone_fetch_addr_N1", m_addr, 32'h100);
      chk("lone_fetch_busy_N1", if_ready, 0);
      step(); #2;
      chk("lone_fetch_rvalid_N2", if_rvalid, 1);
      chk("lone_fetch_rdata_N2", if_rdata, 32'h0000_0013);
      step(); #2;
      chk("lone_fetch_ready_N3", if_ready, 1);
      step(); if_req = 1'b0;
      step(); step(); step();

      // store then load
      d_req = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_we = 4'b0011; #2;
      chk("store_ready", d_ready, 1);
      step(); d_req = 1'b0; d_we = 4'h0; #2;
      chk("store_m_we", m_we, 4'b0011);
      step(); #2;
      chk("store_ack", d_rvalid, 1);
      step(); d_req = 1'b1; d_addr = 32'h200; d_we = 4'h0; #2;
      chk("load_ready", d_ready, 1);
      step(); d_req = 1'b0;
      step(); #2;
      chk("load_rvalid", d_rvalid, 1);
      chk("load_rdata", d_rdata, 32'h0000_BEEF);
      step();

      // reset during ISSUE of a load to 0x40
      d_req = 1'b1; d_addr = 32'h40; d_we = 4'h0; #2;
      chk("rst_issue_accept", d_ready, 1);
      step(); d_req = 1'b0; reset = 1'b1; #2;
      chk("rst_issue_men", m_en, 0);
      step(); reset = 1'b0; d_req = 1'b1; d_addr = 32'h44; #2;
      chk("rst_issue_no_rvalid", d_rvalid, 0);
      chk("rst_issue_next_accept", d_ready, 1);
      step(); d_req = 1'b0;
      step(); step(); step();

      // data request withdrawn while a fetch is in RESP
      men_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) step();
         if_req = (i == 0);
         if_addr = 32'h100;
         d_req = (i == 2);
         d_addr = 32'h300; d_wdata = 32'h55AA_55AA; d_we = 4'hF;
         #2;
         if (m_en) begin
            men_cnt++;
            chk("withdraw_men_addr", m_addr, 32'h100);
         end
      end
      chk("withdraw_men_count", men_cnt, 1);
      d_we = 4'h0;

      // randomized traffic with occasional withdrawals and resets
      for (int c = 0; c < 3000; c++) begin
         step();
         if (acc_if) if_req = 1'b0;
         if (acc_d)  d_req  = 1'b0;
         reset = ($urandom_range(0, 149) == 0);
         if (!if_req) begin
            if ($urandom_range(0, 2) == 0) begin
               if_req  = 1'b1;
               if_addr = 32'($urandom_range(0, 255)) << 2;
            end
         end else if ($urandom_range(0, 19) == 0) begin
            if_req = 1'b0;
         end
         if (!d_req) begin
            if ($urandom_range(0, 2) == 0) begin
               d_req   = 1'b1;
               d_addr  = 32'($urandom_range(0, 255)) << 2;
               d_wdata = $urandom;
               d_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
         end else if ($urandom_range(0, 19) == 0) begin
            d_req = 1'b0;
         end
      end
      step();
      reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
      step(); step(); step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
